// File: rtl/quadrant_drain.sv
// quadrant_drain: snapshots NUM_QUAD accumulator sums and drains them
// as rounded, rescaled, saturated int16 words to the output SRAM port.
module quadrant_drain #(
  parameter int NUM_QUAD   = 4,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_ADDR_W = 12
) (
  input  logic                     clock,
  input  logic                     reset_b,
  input  logic                     acc_valid,
  output logic                     acc_ready,
  input  logic [NUM_QUAD*32-1:0]   acc_data,
  input  logic [OUT_ADDR_W-1:0]    base_addr,
  input  logic                     relu_en,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic [OUT_ADDR_W-1:0]    wr_addr,
  output logic [15:0]              wr_data,
  output logic                     done,
  output logic                     overflow,
  input  logic                     err_clear
);

  localparam int IDX_W =
    (NUM_QUAD > 1) ? $clog2(NUM_QUAD) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_QUAD - 1);
  localparam logic signed [32:0] HALF =
    33'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [32:0] SMAX = 33'sd32767;
  localparam logic signed [32:0] SMIN = -33'sd32768;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [31:0]             shadow_q [NUM_QUAD];
  logic [OUT_ADDR_W-1:0]   base_q;
  logic                    relu_q;
  logic                    overflow_q;
  logic                    capture;
  logic                    drop;

  // 33-bit math keeps the rounding add on 0x7FFFFFFF from wrapping
  function automatic logic [15:0] conv(
    input logic [31:0] x,
    input logic        relu
  );
    logic signed [32:0] r;
    logic signed [32:0] s;
    r = $signed({x[31], x}) + HALF;
    s = r >>> FRAC_SHIFT;
    if (relu && s < 0) s = '0;
    if (s > SMAX)      return 16'h7fff;
    else if (s < SMIN) return 16'h8000;
    else               return s[15:0];
  endfunction

  assign capture = acc_valid && (state_q == IDLE);
  assign drop    = acc_valid && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (acc_valid) begin
          state_d = WRITE;
          idx_d   = '0;
        end
      end
      WRITE: begin
        if (wr_ready) begin
          if (idx_q == LAST) state_d = DONE;
          else               idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      base_q     <= '0;
      relu_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_QUAD; i++)
        shadow_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture) begin
        base_q <= base_addr;
        relu_q <= relu_en;
        for (int i = 0; i < NUM_QUAD; i++)
          shadow_q[i] <= acc_data[32*i +: 32];
      end
      // a new drop wins over a coincident clear
      if (drop)           overflow_q <= 1'b1;
      else if (err_clear) overflow_q <= 1'b0;
    end
  end

  always_comb begin
    acc_ready = (state_q == IDLE);
    wr_en     = (state_q == WRITE);
    done      = (state_q == DONE);
    overflow  = overflow_q;
    wr_addr   = '0;
    wr_data   = '0;
    if (wr_en) begin
      wr_addr = base_q + OUT_ADDR_W'(idx_q);
      wr_data = conv(shadow_q[idx_q], relu_q);
    end
  end

endmodule
